// File: rtl/cabin_pkg.sv
// ============================================================================
// Module : cabin_pkg
// Brief  : Shared terminal-mode codes and timer state encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cabin_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    typedef enum logic [1:0] {
        TMR_IDLE = 2'b00,
        TMR_RUN  = 2'b01,
        TMR_DONE = 2'b10
    } tmr_state_t;

endpackage

`default_nettype wire

// File: rtl/cabin_timer_counter_if.sv
// ============================================================================
// Module : cabin_timer_counter_if
// Brief  : Control/status bundle between a timer client and the timer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface cabin_timer_counter_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             dir_up;
    logic [1:0]       mode;
    logic [WIDTH-1:0] cmp_val;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             cmp_match;
    logic             busy;
    logic             done;

    modport master (
        output en, load, load_val, dir_up, mode, cmp_val,
        input  q, tc, cmp_match, busy, done
    );

    modport slave (
        input  en, load, load_val, dir_up, mode, cmp_val,
        output q, tc, cmp_match, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/cabin_prescaler.sv
// ============================================================================
// Module : cabin_prescaler
// Brief  : Divides enabled clk cycles by PRESCALE; tick marks the last one.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cabin_prescaler #(
    parameter int PRESCALE = 1
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic en,
    input  wire logic clr,
    output logic      tick
);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end
endmodule

`default_nettype wire

// File: rtl/cabin_timer_counter.sv
// ============================================================================
// Module : cabin_timer_counter
// Brief  : Prescaled up/down timer with wrap/saturate/oneshot terminal modes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cabin_timer_counter
    import cabin_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter int PRESCALE = 1
) (
    input  wire logic             clk,
    input  wire logic             reset,
    cabin_timer_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);
    localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MAX_VAL);

    tmr_state_t       state, state_nxt;
    logic [WIDTH-1:0] q, q_nxt;
    logic             tc, tc_nxt;
    logic             run_en;
    logic             step;
    logic [WIDTH:0]   q_inc;
    logic             at_term;
    logic [WIDTH-1:0] load_clamped;

    // DONE freezes the prescaler as well as the count.
    assign run_en = bus.en && (state != TMR_DONE);

    cabin_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (run_en),
        .clr   (bus.load),
        .tick  (step)
    );

    // One extra bit so MAX_VAL = 2**WIDTH-1 is still detected as terminal.
    assign q_inc        = {1'b0, q} + 1'b1;
    assign at_term      = bus.dir_up ? (q_inc > MAX_X) : (q == '0);
    assign load_clamped = ({1'b0, bus.load_val} > MAX_X) ? MAX_Q : bus.load_val;

    always_comb begin
        q_nxt     = q;
        tc_nxt    = 1'b0;
        state_nxt = state;
        if (bus.load) begin
            q_nxt     = load_clamped;
            state_nxt = TMR_IDLE;
        end else begin
            case (state)
                TMR_IDLE: if (bus.en)  state_nxt = TMR_RUN;
                TMR_RUN:  if (!bus.en) state_nxt = TMR_IDLE;
                default:  state_nxt = state;
            endcase
            if (step) begin
                if (!at_term) begin
                    q_nxt = bus.dir_up ? q_inc[WIDTH-1:0] : q - 1'b1;
                end else begin
                    tc_nxt = 1'b1;
                    case (bus.mode)
                        MODE_SAT:     q_nxt = q;
                        MODE_ONESHOT: state_nxt = TMR_DONE;
                        MODE_WRAP:    q_nxt = bus.dir_up ? '0 : MAX_Q;
                        default:      q_nxt = bus.dir_up ? '0 : MAX_Q;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q     <= '0;
            tc    <= 1'b0;
            state <= TMR_IDLE;
        end else begin
            q     <= q_nxt;
            tc    <= tc_nxt;
            state <= state_nxt;
        end
    end

    assign bus.q         = q;
    assign bus.tc        = tc;
    assign bus.cmp_match = (q == bus.cmp_val);
    assign bus.busy      = (state == TMR_RUN);
    assign bus.done      = (state == TMR_DONE);
endmodule

`default_nettype wire

// File: tb/tb_cabin_timer_counter.sv
// ============================================================================
// Module : tb_cabin_timer_counter
// Brief  : Directed vector bench for cabin_timer_counter (MAX_VAL=9, PRESCALE=3).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_cabin_timer_counter;
    import cabin_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    cabin_timer_counter_if #(.WIDTH(8)) bus ();

    cabin_timer_counter #(
        .WIDTH    (8),
        .MAX_VAL  (9),
        .PRESCALE (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       en;
        logic       ld;
        logic [7:0] lv;
        logic       up;
        logic [1:0] md;
        logic [7:0] cmp;
        logic [7:0] q;
        logic       tc;
        logic       busy;
        logic       done;
        logic       cm;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic en, input logic ld, input logic [7:0] lv,
                                input logic up, input logic [1:0] md, input logic [7:0] cmp,
                                input logic [7:0] q, input logic tc, input logic busy,
                                input logic done, input logic cm);
        vec_t v;
        v.en = en; v.ld = ld; v.lv = lv; v.up = up; v.md = md; v.cmp = cmp;
        v.q = q; v.tc = tc; v.busy = busy; v.done = done; v.cm = cm;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] q, input logic tc,
                             input logic busy, input logic done, input logic cm);
        check({tag, ".q"},         32'(bus.q),         32'(q));
        check({tag, ".tc"},        32'(bus.tc),        32'(tc));
        check({tag, ".busy"},      32'(bus.busy),      32'(busy));
        check({tag, ".done"},      32'(bus.done),      32'(done));
        check({tag, ".cmp_match"}, 32'(bus.cmp_match), 32'(cm));
    endtask

    // Drive for one cycle, then sample 1 time unit after the edge.
    task automatic apply(input logic en, input logic ld, input logic [7:0] lv,
                         input logic up, input logic [1:0] md, input logic [7:0] cmp);
        bus.en = en; bus.load = ld; bus.load_val = lv;
        bus.dir_up = up; bus.mode = md; bus.cmp_val = cmp;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] eq;

        // Down saturate, load clamp on a step cycle, hold/resume.
        vecs.push_back(mk(1, 1,   2, 0, MODE_SAT, 0,  2, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0,   0, 0, MODE_SAT, 0,  2, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0,   0, 0, MODE_SAT, 0,  2, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0,   0, 0, MODE_SAT, 0,  1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0,   0, 0, MODE_SAT, 0,  1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0,   0, 0, MODE_SAT, 0,  1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0,   0, 0, MODE_SAT, 0,  0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0,   0, 0, MODE_SAT, 0,  0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0,   0, 0, MODE_SAT, 0,  0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0,   0, 0, MODE_SAT, 0,  0, 1, 1, 0, 1));
        vecs.push_back(mk(1, 0,   0, 0, MODE_SAT, 0,  0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0,   0, 0, MODE_SAT, 0,  0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0,   0, 0, MODE_SAT, 0,  0, 1, 1, 0, 1));
        vecs.push_back(mk(1, 0,   0, 0, MODE_SAT, 0,  0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0,   0, 0, MODE_SAT, 0,  0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 1, 200, 1, MODE_WRAP, 9, 9, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0,   0, 1, MODE_WRAP, 9, 9, 0, 1, 0, 1));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 0, 0, 1, MODE_WRAP, 9, 9, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0,   0, 1, MODE_WRAP, 9, 9, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0,   0, 1, MODE_WRAP, 9, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0,   0, 1, MODE_WRAP, 9, 0, 0, 1, 0, 0));

        // Reset held two cycles with en high.
        reset = 1'b1;
        apply(1, 0, 0, 1, MODE_WRAP, 0);
        apply(1, 0, 0, 1, MODE_WRAP, 0);
        check_all("reset", 0, 0, 0, 0, 1);
        reset = 1'b0;

        // Up wrap through the prescaler: a step every third cycle.
        for (int k = 1; k <= 31; k++) begin
            apply(1, 0, 0, 1, MODE_WRAP, 5);
            eq = 8'((k / 3) % 10);
            check_all($sformatf("wrap[%0d]", k), eq, k == 30, 1, 0, eq == 8'd5);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].en, vecs[i].ld, vecs[i].lv, vecs[i].up, vecs[i].md, vecs[i].cmp);
            check_all($sformatf("vec[%0d]", i), vecs[i].q, vecs[i].tc,
                      vecs[i].busy, vecs[i].done, vecs[i].cm);
        end

        // Oneshot from 7: expires on the third step, then stays frozen.
        apply(1, 1, 7, 1, MODE_ONESHOT, 9);
        check_all("os_load", 7, 0, 0, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            apply(1, 0, 0, 1, MODE_ONESHOT, 9);
            eq = (k < 3) ? 8'd7 : (k < 6) ? 8'd8 : 8'd9;
            check_all($sformatf("os[%0d]", k), eq, k == 9, k < 9, k >= 9, eq == 8'd9);
        end
        apply(0, 1, 3, 1, MODE_ONESHOT, 9);
        check_all("os_reload", 3, 0, 0, 0, 0);

        // Reset mid-count.
        for (int k = 1; k <= 4; k++)
            apply(1, 0, 0, 1, MODE_WRAP, 4);
        check_all("mid_pre", 4, 0, 1, 0, 1);
        reset = 1'b1;
        apply(1, 0, 0, 1, MODE_WRAP, 4);
        check_all("mid_reset", 0, 0, 0, 0, 0);
        reset = 1'b0;

        // Reset while in DONE.
        apply(1, 1, 9, 1, MODE_ONESHOT, 0);
        for (int k = 1; k <= 3; k++)
            apply(1, 0, 0, 1, MODE_ONESHOT, 0);
        check_all("done_pre", 9, 1, 0, 1, 0);
        reset = 1'b1;
        apply(1, 0, 0, 1, MODE_ONESHOT, 0);
        check_all("done_reset", 0, 0, 0, 0, 1);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
